// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin select controller for a shared 4:1 mux. Four requesters
//   (a,b,c,d) compete for one output. A registered one-hot grant is kept
//   together with the matching mux select {sel1,sel0}. The granted
//   requester's data is routed to op. Tenure is capped at HOLD_MAX
//   consecutive cycles while other requesters are waiting.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     req[3:0]   request vector, bit0=a .. bit3=d
//     din_a..d   requester data, WIDTH bits each
//     grant      registered one-hot grant, 0000 = none
//     sel0/sel1  registered mux select (index of the granted requester)
//     op         data of the granted requester, 0 when nothing is granted
//     op_valid   high when any grant bit is set
module rr_mux_arbiter #(
  parameter int WIDTH    = 1,
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din_a,
  input  logic [WIDTH-1:0] din_b,
  input  logic [WIDTH-1:0] din_c,
  input  logic [WIDTH-1:0] din_d,
  output logic [3:0]       grant,
  output logic             sel0,
  output logic             sel1,
  output logic [WIDTH-1:0] op,
  output logic             op_valid
);

  localparam int                CNT_W    = $clog2(HOLD_MAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [3:0]       grant_nxt;
  logic [1:0]       sel, sel_nxt;
  logic [1:0]       ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic [3:0]       others;
  logic [2:0]       pk;
  logic             own_req;

  // Returns {found, index} of the first set bit of r scanning start,
  // start+1, ... (mod 4). Scanning downwards lets the nearest hit win.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      sel      <= 2'b00;
      ptr      <= 2'b00;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      sel      <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // While in GRANT, sel is the owner index and ptr is owner+1, so the
  // rotation search always starts at ptr.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    own_req   = req[sel];
    others    = req & ~(4'b0001 << sel);
    pk        = 3'b000;
    case (state)
      IDLE: begin
        grant_nxt = 4'b0000;
        pk        = pick(req, ptr);
      end
      GRANT: begin
        if (!own_req || hold_cnt == HOLD_LIM) begin
          if (|others) begin
            pk = pick(others, ptr);
          end else if (!own_req) begin
            state_nxt = IDLE;
            grant_nxt = 4'b0000;
            hold_nxt  = '0;
          end
          // Sole requester at the cap: keep ownership, counter saturates.
        end else begin
          hold_nxt = hold_cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = 4'b0000;
      end
    endcase
    if (pk[2]) begin
      state_nxt = GRANT;
      grant_nxt = 4'b0001 << pk[1:0];
      sel_nxt   = pk[1:0];
      ptr_nxt   = pk[1:0] + 2'd1;
      hold_nxt  = CNT_ONE;
    end
  end

  assign sel0     = sel[0];
  assign sel1     = sel[1];
  assign op_valid = |grant;

  always_comb begin
    op = '0;
    if (op_valid) begin
      case (sel)
        2'd0:    op = din_a;
        2'd1:    op = din_b;
        2'd2:    op = din_c;
        default: op = din_d;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
module tb_rr_mux_arbiter;

  localparam int WIDTH    = 8;
  localparam int HOLD_MAX = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       req;
  logic [WIDTH-1:0] din_a, din_b, din_c, din_d;
  logic [3:0]       grant;
  logic             sel0, sel1, op_valid;
  logic [WIDTH-1:0] op;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), priority pointer, tenure.
  int         m_own;
  int         m_ptr;
  int         m_cnt;
  int         m_sel;

  rr_mux_arbiter #(.WIDTH(WIDTH), .HOLD_MAX(HOLD_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .din_a(din_a), .din_b(din_b), .din_c(din_c), .din_d(din_d),
    .grant(grant), .sel0(sel0), .sel1(sel1), .op(op), .op_valid(op_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int start);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] din_of(input int i);
    case (i)
      0: return din_a;
      1: return din_b;
      2: return din_c;
      default: return din_d;
    endcase
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_cnt = 0; m_sel = 0;
  endtask

  task automatic award(input int i);
    m_own = i; m_sel = i; m_ptr = (i + 1) % 4; m_cnt = 1;
  endtask

  task automatic model_step(input logic [3:0] r);
    logic [3:0] oth;
    if (m_own < 0) begin
      if (r != 4'b0) award(first_from(r, m_ptr));
    end else begin
      oth = r;
      oth[m_own] = 1'b0;
      if (!r[m_own] || m_cnt == HOLD_MAX) begin
        if (oth != 4'b0)      award(first_from(oth, m_own + 1));
        else if (!r[m_own]) begin m_own = -1; m_cnt = 0; end
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [3:0] eg;
    eg = (m_own < 0) ? 4'b0 : (4'b0001 << m_own);
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".valid"}, 32'(op_valid), 32'(m_own >= 0));
    chk({tag, ".sel"}, 32'({sel1, sel0}), 32'(m_sel));
    chk({tag, ".op"}, 32'(op), (m_own < 0) ? 32'd0 : 32'(din_of(m_own)));
  endtask

  // Drive req and fresh data, take one clock edge, then compare.
  task automatic step(input logic [3:0] r, input string tag);
    req   = r;
    din_a = WIDTH'($urandom); din_b = WIDTH'($urandom);
    din_c = WIDTH'($urandom); din_d = WIDTH'($urandom);
    @(posedge clk);
    model_step(r);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    logic [3:0] r;
    int hold;
    model_reset();
    rst_n = 1'b0; req = 4'b1111;
    din_a = 8'h11; din_b = 8'h22; din_c = 8'h33; din_d = 8'h44;

    // Reset held with all requests active
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_outputs("rst");
      chk("rst.grant0", 32'(grant), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;
    step(4'b0000, "idle");

    // Single request for c, then release
    step(4'b0100, "c_req");
    chk("c_req.grant", 32'(grant), 32'h4);
    chk("c_req.sel", 32'({sel1, sel0}), 32'd2);
    chk("c_req.op", 32'(op), 32'(din_c));
    step(4'b0000, "c_rel");
    chk("c_rel.valid", 32'(op_valid), 32'd0);
    chk("c_rel.sel", 32'({sel1, sel0}), 32'd2);

    // Full contention: each owner holds HOLD_MAX cycles. ptr=3 now (after c).
    for (int i = 0; i < 4 * HOLD_MAX + 1; i++) step(4'b1111, "full");

    // Drop a while a owns: immediate handoff to b with no empty cycle
    while (grant != 4'b0001) step(4'b1111, "to_a");
    step(4'b1110, "a_drop");
    chk("a_drop.grant", 32'(grant), 32'h2);

    // Sole requester b held: never loses grant, even past the cap
    for (int i = 0; i < 10; i++) begin
      step(4'b0010, "b_only");
      chk("b_only.grant", 32'(grant), 32'h2);
    end

    // Async reset mid-grant of c
    step(4'b0000, "gap");
    step(4'b0100, "c_own");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    chk("async_rst.grant", 32'(grant), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step(4'b1111, "post_rst");
    chk("post_rst.grant", 32'(grant), 32'h1);

    // Randomized traffic with sticky requests to exercise tenure caps
    r = 4'b0;
    for (int i = 0; i < 400; i++) begin
      hold = $urandom_range(0, 3);
      if (hold == 0) r = 4'($urandom);
      else if (hold == 1) r[$urandom_range(0, 3)] ^= 1'b1;
      step(r, "rand");
    end

    // Random async reset pulses among traffic
    for (int j = 0; j < 5; j++) begin
      for (int i = 0; i < 20; i++) step(4'($urandom), "rand2");
      #3 rst_n = 1'b0;
      #1 model_reset();
      check_outputs("rand_rst");
      @(negedge clk); rst_n = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
